// File: rtl/inst_rom_pkg.sv
// Shared definitions for the boot-loadable instruction ROM: instruction-bus width,
// default depth and the loader FSM encoding.
package inst_rom_pkg;

    localparam int INST_BUS_W         = 32;
    localparam int DEFAULT_DEPTH_LOG2 = 10;

    typedef enum logic [2:0] {
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    // The loader only takes bytes while it is still collecting length or data.
    function automatic logic loader_active(input ld_state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/inst_ram.sv
// Word array with one synchronous write port and one combinational read port.
module inst_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    // NOTE: the array has no reset on purpose; contents must survive rst and reload,
    // and a reset loop would stop the array mapping onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom.sv
// Instruction memory for the core, filled at boot from a length-prefixed byte stream;
// holds the core in reset until the whole image has been written.
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce,
    input  logic [31:0]           rom_addr,
    output logic [INST_BUS_W-1:0] rom_data,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  reload,
    output logic                  core_rst,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           ld_words
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    ld_state_e             state;
    logic [15:0]           len;
    logic [1:0]            byte_cnt;
    logic [23:0]           shift;
    logic                  accept;
    logic                  word_commit;
    logic [15:0]           len_next;
    logic [15:0]           words_next;
    logic [INST_BUS_W-1:0] rd_word;
    logic                  addr_in_range;
    logic                  unused_addr_bits;

    assign ld_ready    = loader_active(state) && !reload;
    assign accept      = ld_valid && ld_ready;
    assign len_next    = {len[15:8], ld_byte};
    assign words_next  = ld_words + 16'd1;
    assign word_commit = accept && (state == ST_DATA) && (byte_cnt == 2'd3);

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_LEN_HI;
            len      <= '0;
            byte_cnt <= '0;
            shift    <= '0;
            ld_words <= '0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else if (reload) begin
            state    <= ST_LEN_HI;
            len      <= '0;
            byte_cnt <= '0;
            ld_words <= '0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else if (accept) begin
            case (state)
                ST_LEN_HI: begin
                    len[15:8] <= ld_byte;
                    state     <= ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len[7:0] <= ld_byte;
                    if (len_next == 16'd0) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        core_rst <= 1'b0;
                    end else if (32'(len_next) > DEPTH) begin
                        state <= ST_ERR;
                        err   <= 1'b1;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    byte_cnt <= byte_cnt + 2'd1;
                    shift    <= {shift[15:0], ld_byte};
                    if (byte_cnt == 2'd3) begin
                        ld_words <= words_next;
                        if (words_next == len) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    inst_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (INST_BUS_W)
    ) u_inst_ram (
        .clk   (clk),
        .we    (word_commit),
        .waddr (ld_words[DEPTH_LOG2-1:0]),
        .wdata ({shift, ld_byte}),
        .raddr (rom_addr[DEPTH_LOG2+1:2]),
        .rdata (rd_word)
    );

    // Fetches are word-aligned; the byte-lane bits carry no information here.
    assign unused_addr_bits = &{1'b0, rom_addr[1:0]};
    assign addr_in_range    = (rom_addr[31:DEPTH_LOG2+2] == '0);
    assign rom_data         = (rom_ce && addr_in_range) ? rd_word : '0;

endmodule

// File: tb/tb_inst_rom.sv
// Self-checking bench for inst_rom: directed boot-stream scenarios plus randomized
// images and gaps, checked against a stream-level reference model.
module tb_inst_rom;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_ready;
    logic        reload;
    logic        core_rst;
    logic        done;
    logic        err;
    logic [15:0] ld_words;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected memory image and the bytes the loader took
    // in the current load session.
    logic [31:0] exp_mem [int];
    logic [7:0]  acc [$];
    logic        exp_done;
    logic        exp_err;
    int          exp_words;

    inst_rom dut (
        .clk      (clk),
        .rst      (rst),
        .rom_ce   (rom_ce),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .ld_byte  (ld_byte),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .reload   (reload),
        .core_rst (core_rst),
        .done     (done),
        .err      (err),
        .ld_words (ld_words)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Interpret a session's accepted bytes: 16-bit big-endian length, then packed words.
    task automatic model_session();
        int n;
        int full;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_words = 0;
        if (acc.size() < 2) return;
        n = int'(acc[0]) * 256 + int'(acc[1]);
        if (n == 0) begin
            exp_done = 1'b1;
        end else if (n > 1024) begin
            exp_err = 1'b1;
        end else begin
            full = (acc.size() - 2) / 4;
            if (full > n) full = n;
            for (int i = 0; i < full; i++) begin
                exp_mem[i] = {acc[2+4*i], acc[3+4*i], acc[4+4*i], acc[5+4*i]};
            end
            exp_words = full;
            exp_done  = (full == n);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gapped);
        if (gapped) begin
            repeat ($urandom_range(0, 3)) begin
                ld_valid = 1'b0;
                ld_byte  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        @(posedge clk); #1;
        acc.push_back(b);
        ld_valid = 1'b0;
        ld_byte  = 8'($urandom);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        #1;
        check("ld_ready_during_reload", 32'(ld_ready), 32'd0);
        @(posedge clk); #1;
        reload = 1'b0;
        acc.delete();
        #1;
        check("core_rst_after_reload", 32'(core_rst), 32'd1);
        check("ld_words_after_reload", 32'(ld_words), 32'd0);
        check("ld_ready_after_reload", 32'(ld_ready), 32'd1);
    endtask

    task automatic read_word(input string tag, input int idx);
        rom_ce   = 1'b1;
        rom_addr = 32'(idx * 4) | 32'($urandom_range(0, 3));
        #1;
        check(tag, rom_data, exp_mem[idx]);
    endtask

    task automatic check_status(input string tag);
        model_session();
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_core_rst"}, 32'(core_rst), 32'(!exp_done));
        check({tag, "_ld_words"}, 32'(ld_words), 32'(exp_words));
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'(!exp_done && !exp_err));
    endtask

    initial begin
        logic [7:0] image [10];
        int         n;
        image = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h56, 8'h78};

        rst = 1'b0; rom_ce = 1'b0; rom_addr = '0; ld_byte = '0; ld_valid = 1'b0; reload = 1'b0;
        #12;
        check("reset_ld_ready", 32'(ld_ready), 32'd1);
        check("reset_core_rst", 32'(core_rst), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_ld_words", 32'(ld_words), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Word image, back-to-back.
        for (int i = 0; i < 10; i++) begin
            send_byte(image[i], 1'b0);
            if (i == 8) check("image_core_rst_before_last", 32'(core_rst), 32'd1);
        end
        check_status("image");
        read_word("image_mem0", 0);
        read_word("image_mem1", 1);
        rom_addr = 32'd4; #1;
        check("image_addr4", rom_data, 32'h34215678);

        // Read-path gating.
        rom_ce = 1'b0; #1;
        check("rom_ce_low", rom_data, 32'd0);
        rom_ce = 1'b1; rom_addr = 32'h0000_1000; #1;
        check("addr_out_of_range", rom_data, 32'd0);

        // Zero length.
        pulse_reload();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check_status("zero_len");
        repeat (3) @(posedge clk); #1;
        check("zero_len_ready_stays_low", 32'(ld_ready), 32'd0);

        // Oversize length, then the largest legal length.
        pulse_reload();
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        check_status("oversize");
        ld_valid = 1'b1; ld_byte = 8'hA5;
        repeat (3) @(posedge clk); #1;
        ld_valid = 1'b0;
        check("oversize_err_hold", 32'(err), 32'd1);
        check("oversize_no_words", 32'(ld_words), 32'd0);
        read_word("mem_kept_over_reload", 0);
        pulse_reload();
        check("err_cleared", 32'(err), 32'd0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        check_status("max_len");

        // Gapped stream with junk between valid bytes.
        pulse_reload();
        for (int i = 0; i < 10; i++) send_byte(image[i], 1'b1);
        check_status("gapped");
        read_word("gapped_mem0", 0);
        read_word("gapped_mem1", 1);

        // Reload mid-word: one word committed, one partial word abandoned.
        pulse_reload();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0);
        model_session();
        check("midword_ld_words", 32'(ld_words), 32'd1);
        read_word("midword_mem0", 0);
        pulse_reload();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        check_status("reload_image");
        rom_addr = 32'd0; #1;
        check("reload_image_mem0", rom_data, 32'hAABBCCDD);
        read_word("reload_image_mem1_kept", 1);

        // Randomized images with random gaps.
        repeat (4) begin
            pulse_reload();
            n = $urandom_range(1, 8);
            send_byte(8'(n >> 8), 1'b1);
            send_byte(8'(n), 1'b1);
            for (int i = 0; i < 4 * n; i++) send_byte(8'($urandom), 1'b1);
            check_status("random");
            for (int i = 0; i < n; i++) read_word("random_mem", i);
        end

        // Asynchronous reset between edges mid-DATA.
        pulse_reload();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
        model_session();
        #2; rst = 1'b0; #1;
        check("async_rst_core_rst", 32'(core_rst), 32'd1);
        check("async_rst_ld_ready", 32'(ld_ready), 32'd1);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_ld_words", 32'(ld_words), 32'd0);
        @(negedge clk); rst = 1'b1;
        read_word("async_rst_mem0_kept", 0);
        read_word("async_rst_mem1_kept", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_rom.md
# inst_rom

Boot-loadable instruction memory that drives the core's instruction port (`rom_data_i`) from the core's `rom_ce_o`/`rom_addr_o`. After reset it holds the core in reset, accepts a length-prefixed byte stream over a valid/ready handshake, and packs the bytes big-endian into 32-bit words. It releases the core once the last word is written. A `reload` pulse re-arms the loader.

## Interface
- `DEPTH_LOG2`, 10: memory holds 2^DEPTH_LOG2 words.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rom_ce` in 1: fetch enable from the core.
- `rom_addr` in 32: byte fetch address from the core.
- `rom_data` out 32: instruction to the core.
- `ld_byte` in 8: load-stream byte.
- `ld_valid` in 1: `ld_byte` is valid.
- `ld_ready` out 1: loader accepts a byte this cycle.
- `reload` in 1: single-cycle pulse that restarts loading.
- `core_rst` out 1: active-high reset to the core. Asserted while the image is not loaded.
- `done` out 1: image loaded.
- `err` out 1: length exceeded depth.
- `ld_words` out 16: words written so far.

## Operation
- A byte is accepted on a rising edge with `ld_valid && ld_ready`. Bytes with `ld_valid=0` are ignored.
- Stream format: length N (16-bit, MSB first), then 4·N data bytes. Within each word the first byte goes to [31:24].
- FSM states: LEN_HI, LEN_LO, DATA, DONE, ERR.
  - LEN_HI → LEN_LO on accept; latch len[15:8].
  - LEN_LO on accept: latch len[7:0], then:
    - N==0 → DONE.
    - N > 2^DEPTH_LOG2 → ERR.
    - otherwise → DATA.
  - DATA: 2-bit byte counter. The 4th byte of a word writes `mem[ld_words] = {shift[23:0], ld_byte}` on the same edge and increments `ld_words`. When `ld_words` reaches N, go to DONE.
  - DONE and ERR hold until `reload` or `rst`. ERR is left only by `reload` or `rst`.
- `reload` has priority in every state:
  - next edge goes to LEN_HI and clears `ld_words`, the byte counter, `done` and `err`;
  - next edge sets `core_rst`;
  - memory contents are kept;
  - `ld_ready` is 0 in the cycle `reload` is high, so no byte is lost ambiguously.
- `ld_ready = (state ∈ {LEN_HI, LEN_LO, DATA}) && !reload`.
- Read path is combinational:
  - `rom_data = mem[rom_addr[DEPTH_LOG2+1:2]]` when `rom_ce=1` and `rom_addr[31:DEPTH_LOG2+2]==0`;
  - otherwise `rom_data = 0`;
  - `rom_addr[1:0]` is ignored.
- Unwritten words read unspecified data.
- Memory is not cleared by reset.

## Timing
- Reset values (applied asynchronously while `rst=0`):
  - state LEN_HI, so `ld_ready=1`;
  - `core_rst=1`, `done=0`, `err=0`, `ld_words=0`;
  - byte counter 0, length 0.
- `core_rst`, `done` and `err` are registered and change on the edge that enters DONE or ERR. So `core_rst` falls in the cycle after the final byte is accepted.
- A write on edge k is visible on `rom_data` after edge k, for a matching address.
- Throughput: 1 byte per cycle. A word commits on every 4th accepted byte.
- A reset assertion mid-load aborts immediately. Partial words are discarded and words already written are retained.

## Structure
- FSM state encodings and the default depth go in the shared define file, next to the existing instruction-bus macros.
- `rom_data` width uses the same instruction-bus macro as the core.
- One natural sub-module, `inst_ram`: a 1-write, 1-async-read word array. The loader FSM stays in `inst_rom`.

## Test plan
- Word image: reset, then stream `00 02 3C 01 12 34 34 21 56 78` back-to-back.
  - Expect `mem[0]=3C011234`, `mem[1]=34215678`, `ld_words=2`.
  - `done=1` and `core_rst=0` on the cycle after the last byte.
  - `rom_ce=1`, `rom_addr=4` gives `rom_data=34215678`.
- Zero length: stream `00 00`. Expect `done=1` and `core_rst=0` after the 2nd byte, and `ld_ready=0` from then on.
- Oversize length: stream `04 01` (1025 > 1024).
  - Expect `err=1`, `ld_ready=0`, `core_rst=1`.
  - Further valid bytes are not accepted.
  - `reload` clears `err` and restores `ld_ready=1`.
- Gapped stream: same stream as the word-image test, with `ld_valid` toggled randomly and junk on `ld_byte` while invalid. Expect results identical to the word-image test.
- Reload mid-word: `reload` after 5 data bytes, then stream `00 01 AA BB CC DD`.
  - In the `reload` cycle, `ld_ready=0`.
  - Expect `mem[0]=AABBCCDD`, `ld_words=1`, `done=1`.
- Reset and read-path edge cases:
  - `rst` low between edges mid-DATA: expect `core_rst=1`, `ld_ready=1`, `done=0` immediately.
  - `rom_ce=0`: expect `rom_data=0`.
  - `rom_addr=0x1000` with `rom_ce=1`: expect `rom_data=0`.
